hyper_arb: RTL

Round-robin arbiter that shares one HyperRAM controller (`hyper_xface`) between `NUM_PORTS` single-dword requesters. It sits between client logic and the controller's command/data port. It accepts one read or write per grant, issues it as a single-cycle `rd_req`/`wr_req` pulse, and tracks the controller's `busy`/`rd_rdy` handshake. It returns a per-port completion pulse, with read data, before arbitrating again.

---
 rtl/hyper_arb.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/hyper_arb.sv
// hyper_arb: round-robin arbiter sharing one HyperRAM controller between
// NUM_PORTS single-dword requesters, with one command outstanding at a time.
module hyper_arb #(
    parameter int NUM_PORTS = 4,
    parameter int BUSY_TO   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_PORTS-1:0]    req_valid,
    input  logic [NUM_PORTS-1:0]    req_we,
    input  logic [32*NUM_PORTS-1:0] req_addr,
    input  logic [32*NUM_PORTS-1:0] req_wdata,
    input  logic [4*NUM_PORTS-1:0]  req_be,
    output logic [NUM_PORTS-1:0]    req_ready,
    output logic [NUM_PORTS-1:0]    rsp_valid,
    output logic [31:0]             rsp_rdata,
    output logic                    err,
    output logic                    rd_req,
    output logic                    wr_req,
    output logic [31:0]             addr,
    output logic [31:0]             wr_d,
    output logic [3:0]              wr_byte_en,
    output logic [5:0]              rd_num_dwords,
    input  logic                    busy,
    input  logic                    rd_rdy,
    input  logic [31:0]             rd_d
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = $clog2(BUSY_TO + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(BUSY_TO - 1);
    localparam logic [PW-1:0] LAST_RST = PW'(NUM_PORTS - 1);
    localparam logic [NUM_PORTS-1:0] ONE = {{(NUM_PORTS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t               state_r, state_nxt_s;
    logic [PW-1:0]        last_r, grant_s;
    logic                 grant_vld_s;
    logic                 we_r, got_r, err_r;
    logic [CW-1:0]        cnt_r;
    logic [NUM_PORTS-1:0] req_ready_r, rsp_valid_r;
    logic                 rd_req_r, wr_req_r;
    logic [31:0]          addr_r, wr_d_r, rsp_rdata_r;
    logic [3:0]           be_r;
    logic                 sel_we_s;
    logic [31:0]          sel_addr_s, sel_wdata_s;
    logic [3:0]           sel_be_s;
    logic                 grant_fire_s, rsp_fire_s, rsp_zero_s, rsp_cap_s, err_set_s;

    assign req_ready     = req_ready_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_rdata     = rsp_rdata_r;
    assign err           = err_r;
    assign rd_req        = rd_req_r;
    assign wr_req        = wr_req_r;
    assign addr          = addr_r;
    assign wr_d          = wr_d_r;
    assign wr_byte_en    = be_r;
    assign rd_num_dwords = 6'h1;

    // Rotating priority search starting one past the last granted port.
    always_comb begin : arb_p
        logic [PW-1:0] idx_v;
        grant_s     = last_r;
        grant_vld_s = 1'b0;
        idx_v       = last_r;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx_v       = PW'((int'(last_r) + i) % NUM_PORTS);
            grant_s     = (!grant_vld_s && req_valid[idx_v]) ? idx_v : grant_s;
            grant_vld_s = grant_vld_s | req_valid[idx_v];
        end
    end

    // Select the winning port's request fields.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = 32'h0;
        sel_wdata_s = 32'h0;
        sel_be_s    = 4'h0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sel_we_s    = (grant_s == PW'(i)) ? req_we[i]             : sel_we_s;
            sel_addr_s  = (grant_s == PW'(i)) ? req_addr[32*i +: 32]  : sel_addr_s;
            sel_wdata_s = (grant_s == PW'(i)) ? req_wdata[32*i +: 32] : sel_wdata_s;
            sel_be_s    = (grant_s == PW'(i)) ? req_be[4*i +: 4]      : sel_be_s;
        end
    end

    // Next-state and per-cycle transaction decisions.
    always_comb begin
        state_nxt_s  = state_r;
        grant_fire_s = 1'b0;
        rsp_fire_s   = 1'b0;
        rsp_zero_s   = 1'b0;
        rsp_cap_s    = 1'b0;
        err_set_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_vld_s && !busy) begin
                    grant_fire_s = 1'b1;
                    state_nxt_s  = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                state_nxt_s = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (busy) begin
                    state_nxt_s = WAIT_DONE;
                end else if (cnt_r == TO_LAST) begin
                    err_set_s   = 1'b1;
                    rsp_fire_s  = 1'b1;
                    rsp_zero_s  = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                if (we_r) begin
                    if (!busy) begin
                        rsp_fire_s  = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = WAIT_DONE;
                    end
                end else begin
                    // Only the first read strobe is returned; a drop of busy without one is an error.
                    if (rd_rdy && !got_r) begin
                        rsp_fire_s = 1'b1;
                        rsp_cap_s  = 1'b1;
                    end else begin
                        rsp_cap_s = 1'b0;
                    end
                    if (!busy) begin
                        state_nxt_s = IDLE;
                        if (!got_r && !rd_rdy) begin
                            rsp_fire_s = 1'b1;
                            rsp_zero_s = 1'b1;
                            err_set_s  = 1'b1;
                        end else begin
                            rsp_zero_s = 1'b0;
                        end
                    end else begin
                        state_nxt_s = WAIT_DONE;
                    end
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, grant pointer, command and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            last_r      <= LAST_RST;
            we_r        <= 1'b0;
            got_r       <= 1'b0;
            err_r       <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            req_ready_r <= {NUM_PORTS{1'b0}};
            rsp_valid_r <= {NUM_PORTS{1'b0}};
            rd_req_r    <= 1'b0;
            wr_req_r    <= 1'b0;
            addr_r      <= 32'h0;
            wr_d_r      <= 32'h0;
            be_r        <= 4'h0;
            rsp_rdata_r <= 32'h0;
        end else begin
            state_r     <= state_nxt_s;
            req_ready_r <= {NUM_PORTS{1'b0}};
            rsp_valid_r <= {NUM_PORTS{1'b0}};
            rd_req_r    <= 1'b0;
            wr_req_r    <= 1'b0;
            if (grant_fire_s) begin
                last_r      <= grant_s;
                we_r        <= sel_we_s;
                got_r       <= 1'b0;
                addr_r      <= sel_addr_s;
                wr_d_r      <= sel_wdata_s;
                be_r        <= sel_be_s;
                req_ready_r <= ONE << grant_s;
                rd_req_r    <= ~sel_we_s;
                wr_req_r    <= sel_we_s;
            end
            if (state_r == ISSUE) begin
                cnt_r <= {CW{1'b0}};
            end else if (state_r == WAIT_BUSY) begin
                cnt_r <= cnt_r + CW'(1);
            end
            if (rsp_fire_s) begin
                rsp_valid_r <= ONE << last_r;
            end
            if (rsp_zero_s) begin
                rsp_rdata_r <= 32'h0;
            end else if (rsp_cap_s) begin
                rsp_rdata_r <= rd_d;
            end
            if (rsp_cap_s) begin
                got_r <= 1'b1;
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end
        end
    end

endmodule
